reg_writeback_queue: RTL and testbench
======================================

// Module: reg_writeback_queue
// PURPOSE
//  Writeback stage directly upstream of the register bank: accepts results from the ALU and
//  memory units over valid/ready handshakes, buffers them in an in-order FIFO, and drains at
//  most one result per cycle onto the bank's dest/Din write port. Exports a pending-register
//  mask so decode can stall on read-after-write hazards.
// PARAMETERS
//  DATA_W  32  result width, matches register bank Din
//  ADDR_W  4   register address width (16 registers)
//  DEPTH   4   FIFO entries; power of two, >= 2
// PORTS
//  clk        in   1       single clock, all state updates on rising edge
//  rst_n      in   1       asynchronous, active-low reset
//  alu_valid  in   1       ALU result offered
//  alu_dest   in   ADDR_W  ALU destination register
//  alu_data   in   DATA_W  ALU result
//  alu_ready  out  1       ALU result accepted this cycle when valid&ready
//  mem_valid  in   1       memory load result offered
//  mem_dest   in   ADDR_W  load destination register
//  mem_data   in   DATA_W  load result
//  mem_ready  out  1       load accepted this cycle when valid&ready
//  flush      in   1       synchronous discard of all queued results
//  wb_stall   in   1       bank write port unavailable; hold head
//  wb_we      out  1       write strobe to register bank, one cycle per result
//  wb_dest    out  ADDR_W  drives bank dest
//  wb_din     out  DATA_W  drives bank Din
//  busy_mask  out  16      bit r set while any queued entry targets register r
// BEHAVIOUR
//  - Reset (rst_n=0, async): count=0, rd/wr pointers=0, wb_we=0, wb_dest=0, wb_din=0,
//    busy_mask=0, alu_ready=1, mem_ready=1. Entry contents not cleared.
//  - Occupancy states from registered count: EMPTY (0), PARTIAL, FULL (DEPTH).
//  - alu_ready = (count <= DEPTH-1). mem_ready = (count <= DEPTH-2) | (count == DEPTH-1 & !alu_valid).
//    Readies are based on registered count only; a same-cycle pop does not create room.
//  - Simultaneous ALU+MEM accept: both written same edge, ALU entry older (drains first).
//  - Drain: if count>0 and !wb_stall, pop head at edge; wb_we=1, wb_dest/wb_din=head on
//    the following cycle. Otherwise wb_we=0; wb_dest/wb_din hold last values.
//  - Latency: result accepted at edge N appears on wb_* after edge N+1 at earliest. No
//    FIFO bypass when EMPTY.
//  - Push and pop same edge: count += pushes - pop; count never exceeds DEPTH or wraps below 0.
//  - Pointers wrap modulo DEPTH.
//  - busy_mask: combinational OR of one-hot(dest) over valid entries plus wb_dest while wb_we=1.
//  - flush=1: at edge count=0, pointers=0, wb_we=0; same-cycle offers are not accepted
//    (alu_ready=mem_ready=0 while flush=1).
//  - Reset asserted mid-drain: wb_we drops immediately; queued results lost.
// CONFIGURATION
//  - WB_FORWARD_EN defined: adds ports fwd_addr (in, ADDR_W), fwd_hit (out, 1),
//    fwd_data (out, DATA_W). Combinational lookup returns the youngest match among
//    queued entries, then the wb_* output stage; fwd_hit=0, fwd_data=0 if none.
//  - WB_FORWARD_EN undefined: ports absent; decode relies on busy_mask stalls only.
// TESTING
//  1. Reset, then ALU push dest=1 data=0x1 -> after 2 edges wb_we=1, wb_dest=1,
//     wb_din=0x00000001 for exactly one cycle; busy_mask[1] high until then.
//  2. ALU (dest=2, 0xAAAA) and MEM (dest=3, 0x5555) same cycle -> both accepted; drains
//     dest=2 then dest=3 on consecutive cycles.
//  3. wb_stall=1, push 4 entries -> count=4, alu_ready=0, mem_ready=0; 5th offer held;
//     release stall -> 4 writes in order, then 5th.
//  4. count=3, alu_valid=mem_valid=1 -> ALU accepted, mem_ready=0; MEM accepted next cycle.
//  5. Queue 3 entries, flush=1 -> next cycle count=0, busy_mask=0, no wb_we.
//  6. WB_FORWARD_EN: queue dest=5 0x10 then dest=5 0x20, fwd_addr=5 -> fwd_hit=1,
//     fwd_data=0x20; fwd_addr=6 -> fwd_hit=0.

Source files
------------

// File: rtl/reg_writeback_queue.sv
// rtl/reg_writeback_queue.sv - in-order writeback FIFO draining ALU/MEM results into the register bank
// Optional macro WB_FORWARD_EN adds a combinational forwarding lookup (fwd_addr/fwd_hit/fwd_data).
module reg_writeback_queue #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 4,
   parameter int DEPTH  = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              alu_valid,
   input  logic [ADDR_W-1:0] alu_dest,
   input  logic [DATA_W-1:0] alu_data,
   output logic              alu_ready,
   input  logic              mem_valid,
   input  logic [ADDR_W-1:0] mem_dest,
   input  logic [DATA_W-1:0] mem_data,
   output logic              mem_ready,
   input  logic              flush,
   input  logic              wb_stall,
   output logic              wb_we,
   output logic [ADDR_W-1:0] wb_dest,
   output logic [DATA_W-1:0] wb_din,
`ifdef WB_FORWARD_EN
   input  logic [ADDR_W-1:0] fwd_addr,
   output logic              fwd_hit,
   output logic [DATA_W-1:0] fwd_data,
`endif
   output logic [15:0]       busy_mask
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;
   localparam logic [CW-1:0] C_FULL    = CW'(DEPTH);
   localparam logic [CW-1:0] C_FULL_M1 = CW'(DEPTH - 1);
   localparam logic [CW-1:0] C_FULL_M2 = CW'(DEPTH - 2);

   typedef enum logic [1:0] {OCC_EMPTY, OCC_PARTIAL, OCC_FULL} occ_t;

   logic [ADDR_W-1:0] r_dest [DEPTH];
   logic [DATA_W-1:0] r_data [DEPTH];
   logic [PW-1:0]     r_wr_ptr;
   logic [PW-1:0]     r_rd_ptr;
   logic [CW-1:0]     r_count;
   logic              r_wb_we;
   logic [ADDR_W-1:0] r_wb_dest;
   logic [DATA_W-1:0] r_wb_din;

   occ_t              w_occ;
   logic              w_push_alu;
   logic              w_push_mem;
   logic              w_pop;
   logic [PW-1:0]     w_mem_slot;

   always_comb begin
      w_occ = OCC_PARTIAL;
      if (r_count == '0)
         w_occ = OCC_EMPTY;
      else if (r_count == C_FULL)
         w_occ = OCC_FULL;
   end

   // Readies look only at registered occupancy; a pop in the same cycle does not make room.
   assign alu_ready  = !flush && (w_occ != OCC_FULL);
   assign mem_ready  = !flush && ((r_count <= C_FULL_M2) || ((r_count == C_FULL_M1) && !alu_valid));
   assign w_push_alu = alu_valid && alu_ready;
   assign w_push_mem = mem_valid && mem_ready;
   assign w_pop      = (w_occ != OCC_EMPTY) && !wb_stall && !flush;
   assign w_mem_slot = r_wr_ptr + PW'(w_push_alu);

   always_ff @(posedge clk) begin
      if (w_push_alu) begin
         r_dest[r_wr_ptr] <= alu_dest;
         r_data[r_wr_ptr] <= alu_data;
      end
      if (w_push_mem) begin
         r_dest[w_mem_slot] <= mem_dest;
         r_data[w_mem_slot] <= mem_data;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_count   <= '0;
         r_wr_ptr  <= '0;
         r_rd_ptr  <= '0;
         r_wb_we   <= 1'b0;
         r_wb_dest <= '0;
         r_wb_din  <= '0;
      end else if (flush) begin
         r_count  <= '0;
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_wb_we  <= 1'b0;
      end else begin
         r_wr_ptr <= r_wr_ptr + PW'(w_push_alu) + PW'(w_push_mem);
         r_count  <= r_count + CW'(w_push_alu) + CW'(w_push_mem) - CW'(w_pop);
         r_wb_we  <= w_pop;
         if (w_pop) begin
            r_rd_ptr  <= r_rd_ptr + PW'(1);
            r_wb_dest <= r_dest[r_rd_ptr];
            r_wb_din  <= r_data[r_rd_ptr];
         end
      end
   end

   assign wb_we   = r_wb_we;
   assign wb_dest = r_wb_dest;
   assign wb_din  = r_wb_din;

   always_comb begin
      busy_mask = '0;
      for (int k = 0; k < DEPTH; k++) begin
         if (CW'(k) < r_count)
            busy_mask = busy_mask | (16'd1 << r_dest[r_rd_ptr + PW'(k)]);
      end
      if (r_wb_we)
         busy_mask = busy_mask | (16'd1 << r_wb_dest);
   end

`ifdef WB_FORWARD_EN
   // Oldest source first so the youngest matching entry wins.
   always_comb begin
      fwd_hit  = 1'b0;
      fwd_data = '0;
      if (r_wb_we && (r_wb_dest == fwd_addr)) begin
         fwd_hit  = 1'b1;
         fwd_data = r_wb_din;
      end
      for (int k = 0; k < DEPTH; k++) begin
         if ((CW'(k) < r_count) && (r_dest[r_rd_ptr + PW'(k)] == fwd_addr)) begin
            fwd_hit  = 1'b1;
            fwd_data = r_data[r_rd_ptr + PW'(k)];
         end
      end
   end
`endif

endmodule

// File: tb/tb_reg_writeback_queue.sv
// tb/tb_reg_writeback_queue.sv - self-checking bench for reg_writeback_queue
// Vector table plus scoreboard reference model; forwarding checks under WB_FORWARD_EN.
module tb_reg_writeback_queue;

   localparam int DEPTH = 4;
   localparam int NV    = 28;

   typedef struct {
      logic [3:0]  dest;
      logic [31:0] data;
   } ent_t;

   typedef struct {
      logic        av;
      logic [3:0]  ad;
      logic [31:0] adat;
      logic        mv;
      logic [3:0]  md;
      logic [31:0] mdat;
      logic        st;
      logic        fl;
      logic        ear;
      logic        emr;
   } vec_t;

   logic        clk;
   logic        rst_n;
   logic        alu_valid;
   logic [3:0]  alu_dest;
   logic [31:0] alu_data;
   logic        alu_ready;
   logic        mem_valid;
   logic [3:0]  mem_dest;
   logic [31:0] mem_data;
   logic        mem_ready;
   logic        flush;
   logic        wb_stall;
   logic        wb_we;
   logic [3:0]  wb_dest;
   logic [31:0] wb_din;
   logic [15:0] busy_mask;
`ifdef WB_FORWARD_EN
   logic [3:0]  fwd_addr;
   logic        fwd_hit;
   logic [31:0] fwd_data;
`endif

   reg_writeback_queue #(.DATA_W(32), .ADDR_W(4), .DEPTH(DEPTH)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .alu_valid (alu_valid),
      .alu_dest  (alu_dest),
      .alu_data  (alu_data),
      .alu_ready (alu_ready),
      .mem_valid (mem_valid),
      .mem_dest  (mem_dest),
      .mem_data  (mem_data),
      .mem_ready (mem_ready),
      .flush     (flush),
      .wb_stall  (wb_stall),
      .wb_we     (wb_we),
      .wb_dest   (wb_dest),
      .wb_din    (wb_din),
`ifdef WB_FORWARD_EN
      .fwd_addr  (fwd_addr),
      .fwd_hit   (fwd_hit),
      .fwd_data  (fwd_data),
`endif
      .busy_mask (busy_mask)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int          n_tests = 0;
   int          n_fail  = 0;
   ent_t        sb[$];
   logic        m_we    = 1'b0;
   logic [3:0]  m_dest  = '0;
   logic [31:0] m_din   = '0;
   vec_t        vt [NV];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic vec_t mk(input logic av, input logic [3:0] ad, input logic [31:0] adat,
                               input logic mv, input logic [3:0] md, input logic [31:0] mdat,
                               input logic st, input logic fl, input logic ear, input logic emr);
      vec_t v;
      v.av = av; v.ad = ad; v.adat = adat;
      v.mv = mv; v.md = md; v.mdat = mdat;
      v.st = st; v.fl = fl; v.ear = ear; v.emr = emr;
      return v;
   endfunction

   function automatic vec_t idle(input logic st);
      return mk(0, 0, 0, 0, 0, 0, st, 0, 1, 1);
   endfunction

   function automatic logic [15:0] model_mask();
      logic [15:0] m;
      m = '0;
      foreach (sb[i]) m = m | (16'd1 << sb[i].dest);
      if (m_we) m = m | (16'd1 << m_dest);
      return m;
   endfunction

   task automatic drive(input vec_t v);
      alu_valid = v.av; alu_dest = v.ad; alu_data = v.adat;
      mem_valid = v.mv; mem_dest = v.md; mem_data = v.mdat;
      wb_stall  = v.st; flush = v.fl;
      #1;
   endtask

   // Compare pre-edge outputs with the reference model, advance the model, clock, compare wb_*.
   task automatic tick();
      ent_t e;
      logic m_ar, m_mr, pa, pm, pp;
      m_ar = !flush && (sb.size() < DEPTH);
      m_mr = !flush && ((sb.size() <= DEPTH - 2) || ((sb.size() == DEPTH - 1) && !alu_valid));
      chk("alu_ready", alu_ready, m_ar);
      chk("mem_ready", mem_ready, m_mr);
      chk("busy_mask", busy_mask, model_mask());
      pa = alu_valid && m_ar;
      pm = mem_valid && m_mr;
      pp = (sb.size() > 0) && !wb_stall && !flush;
      if (flush) begin
         sb.delete();
         m_we = 1'b0;
      end else begin
         m_we = pp;
         if (pp) begin
            e = sb.pop_front();
            m_dest = e.dest;
            m_din  = e.data;
         end
         if (pa) begin e.dest = alu_dest; e.data = alu_data; sb.push_back(e); end
         if (pm) begin e.dest = mem_dest; e.data = mem_data; sb.push_back(e); end
      end
      @(posedge clk);
      #1;
      chk("wb_we", wb_we, m_we);
      chk("wb_dest", wb_dest, m_dest);
      chk("wb_din", wb_din, m_din);
   endtask

   initial begin
      vt[0]  = mk(1, 1, 32'h1,    0, 0,  0,       0, 0, 1, 1);
      vt[1]  = idle(0);
      vt[2]  = idle(0);
      vt[3]  = mk(1, 2, 32'hAAAA, 1, 3,  32'h5555, 0, 0, 1, 1);
      vt[4]  = idle(0);
      vt[5]  = idle(0);
      vt[6]  = idle(0);
      vt[7]  = mk(1, 4, 32'h44,   1, 5,  32'h55,  1, 0, 1, 1);
      vt[8]  = mk(1, 6, 32'h66,   1, 7,  32'h77,  1, 0, 1, 1);
      vt[9]  = mk(1, 8, 32'h88,   0, 0,  0,       1, 0, 0, 0);
      vt[10] = mk(1, 8, 32'h88,   0, 0,  0,       0, 0, 0, 0);
      vt[11] = mk(1, 8, 32'h88,   0, 0,  0,       0, 0, 1, 0);
      vt[12] = idle(0);
      vt[13] = idle(0);
      vt[14] = idle(0);
      vt[15] = idle(0);
      vt[16] = mk(1, 9, 32'h9,    1, 10, 32'hA,   1, 0, 1, 1);
      vt[17] = mk(1, 11, 32'hB,   0, 0,  0,       1, 0, 1, 1);
      vt[18] = mk(1, 12, 32'hC,   1, 13, 32'hD,   0, 0, 1, 0);
      vt[19] = mk(0, 0, 0,        1, 13, 32'hD,   0, 0, 1, 1);
      vt[20] = idle(0);
      vt[21] = idle(0);
      vt[22] = idle(0);
      vt[23] = idle(0);
      vt[24] = mk(1, 1, 32'h100,  1, 2,  32'h200, 1, 0, 1, 1);
      vt[25] = mk(1, 3, 32'h300,  0, 0,  0,       1, 0, 1, 1);
      vt[26] = mk(1, 4, 32'h400,  1, 5,  32'h500, 0, 1, 0, 0);
      vt[27] = idle(0);

      rst_n = 1'b0;
      alu_valid = 0; alu_dest = 0; alu_data = 0;
      mem_valid = 0; mem_dest = 0; mem_data = 0;
      flush = 0; wb_stall = 0;
`ifdef WB_FORWARD_EN
      fwd_addr = 0;
`endif
      #12;
      chk("rst wb_we", wb_we, 0);
      chk("rst wb_dest", wb_dest, 0);
      chk("rst wb_din", wb_din, 0);
      chk("rst busy_mask", busy_mask, 0);
      chk("rst alu_ready", alu_ready, 1);
      chk("rst mem_ready", mem_ready, 1);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      for (int i = 0; i < NV; i++) begin
         drive(vt[i]);
         chk($sformatf("vec%0d alu_ready", i), alu_ready, vt[i].ear);
         chk($sformatf("vec%0d mem_ready", i), mem_ready, vt[i].emr);
         tick();
      end
      chk("post-flush busy_mask", busy_mask, 0);
      chk("post-flush wb_we", wb_we, 0);

      // Explicit latency for a single ALU result: visible only after the second edge.
      drive(mk(1, 6, 32'h1234, 0, 0, 0, 0, 0, 1, 1));
      tick();
      chk("lat edge1 wb_we", wb_we, 0);
      chk("lat edge1 busy6", busy_mask[6], 1);
      drive(idle(0));
      tick();
      chk("lat edge2 wb_we", wb_we, 1);
      chk("lat edge2 wb_dest", wb_dest, 6);
      chk("lat edge2 busy6", busy_mask[6], 1);
      drive(idle(0));
      tick();
      chk("lat edge3 wb_we", wb_we, 0);
      chk("lat edge3 busy", busy_mask, 0);

`ifdef WB_FORWARD_EN
      drive(mk(1, 5, 32'h10, 0, 0, 0, 1, 0, 1, 1));
      tick();
      drive(mk(1, 5, 32'h20, 0, 0, 0, 1, 0, 1, 1));
      tick();
      drive(idle(1));
      fwd_addr = 5;
      #1;
      chk("fwd hit5", fwd_hit, 1);
      chk("fwd data5", fwd_data, 32'h20);
      fwd_addr = 6;
      #1;
      chk("fwd hit6", fwd_hit, 0);
      chk("fwd data6", fwd_data, 0);
      tick();
      drive(mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 0));
      tick();
`endif

      // Reset asserted while a result is on the write port and another is queued.
      drive(mk(1, 14, 32'hE, 1, 15, 32'hF, 0, 0, 1, 1));
      tick();
      drive(idle(0));
      tick();
      chk("pre-rst wb_we", wb_we, 1);
      #2;
      rst_n = 1'b0;
      #1;
      chk("midrst wb_we", wb_we, 0);
      chk("midrst wb_dest", wb_dest, 0);
      chk("midrst wb_din", wb_din, 0);
      chk("midrst busy_mask", busy_mask, 0);
      chk("midrst alu_ready", alu_ready, 1);
      sb.delete();
      m_we = 1'b0; m_dest = '0; m_din = '0;
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      drive(idle(0));
      tick();
      drive(idle(0));
      tick();

      for (int i = 0; i < 80; i++) begin
         drive(mk($urandom_range(0, 1), 4'($urandom_range(0, 15)), $urandom,
                  $urandom_range(0, 1), 4'($urandom_range(0, 15)), $urandom,
                  ($urandom_range(0, 2) == 0), ($urandom_range(0, 15) == 0), 1, 1));
         tick();
      end
      for (int i = 0; i < 8; i++) begin
         drive(idle(0));
         tick();
      end
      chk("final queue empty", 32'(sb.size()), 0);
      chk("final busy_mask", busy_mask, 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
